// File: rtl/aud_rec_pkg.sv
// Shared types and constants for the audio record writer.
// Optional build macro: REC_GAIN_EN (adds a saturating input gain stage).
package aud_rec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_L,
        ST_SKIP,
        ST_SHIFT,
        ST_WRITE,
        ST_PAUSED,
        ST_DONE
    } rec_state_t;

    localparam int          I2S_BITS  = 16;
    localparam int          WE_CYCLES = 2;
    localparam logic [15:0] SAT_POS   = 16'h7FFF;
    localparam logic [15:0] SAT_NEG   = 16'h8000;

    // Arithmetic left shift by 0..3 with clamping to the signed 16-bit range.
    function automatic logic [15:0] gain_sat(input logic [15:0] s, input logic [1:0] g);
        logic signed [18:0] w;
        w = signed'({{3{s[15]}}, s}) <<< g;
        if (w > 19'sd32767)
            return SAT_POS;
        else if (w < -19'sd32768)
            return SAT_NEG;
        else
            return w[15:0];
    endfunction

endpackage

// File: rtl/aud_rec_writer_sync.sv
// Multi-flop synchroniser for one asynchronous codec pin, with one-cycle
// rise/fall pulses derived from the synchronised level.
module aud_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the pin through the synchroniser and remember last stable level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_q    = r_sync[SYNC_STAGES-1];
    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/aud_rec_writer.sv
// I2S left-channel capture into external SRAM with start/pause/stop control.
// Optional build macro: REC_GAIN_EN adds i_gain[1:0] (saturating left shift).
module aud_rec_writer
    import aud_rec_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int MEM_DEPTH   = 1048576,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_bclk,
    input  logic              i_adclrck,
    input  logic              i_adcdat,
`ifdef REC_GAIN_EN
    input  logic [1:0]        i_gain,
`endif
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_data,
    output logic              o_sram_we_n,
    output logic [ADDR_W:0]   o_rec_len,
    output logic              o_busy,
    output logic              o_full
);

    localparam int            LW      = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_L = LW'(MEM_DEPTH);

    rec_state_t              r_state;
    logic [ADDR_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_data;
    logic                    r_we_n;
    logic [ADDR_W:0]         r_len;
    logic                    r_full;
    logic [DATA_W-2:0]       r_shift;
    logic [4:0]              r_bit_cnt;
    logic [1:0]              r_we_cnt;
    logic                    r_pend_stop;
    logic                    r_pend_pause;
    logic [SYNC_STAGES-1:0]  r_dat_sync;

    logic                    w_bclk_rise;
    logic                    w_bclk_q_unused;
    logic                    w_bclk_fall_unused;
    logic                    w_lr_rise;
    logic                    w_lr_fall;
    logic                    w_lr_q_unused;
    logic                    w_dat;
    logic [DATA_W-1:0]       w_shift_nx;
    logic [DATA_W-1:0]       w_wdata;
    logic [ADDR_W:0]         w_len_nx;

    aud_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_bclk),
        .o_q    (w_bclk_q_unused),
        .o_rise (w_bclk_rise),
        .o_fall (w_bclk_fall_unused)
    );

    aud_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lr_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_adclrck),
        .o_q    (w_lr_q_unused),
        .o_rise (w_lr_rise),
        .o_fall (w_lr_fall)
    );

    // Data pin gets the same depth as bclk so it lines up with the rise pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_dat_sync <= '0;
        else
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_adcdat};
    end

    assign w_dat      = r_dat_sync[SYNC_STAGES-1];
    assign w_shift_nx = {r_shift, w_dat};
    assign w_len_nx   = r_len + 1'b1;

`ifdef REC_GAIN_EN
    assign w_wdata = gain_sat(w_shift_nx, i_gain);
`else
    assign w_wdata = w_shift_nx;
`endif

    // Capture FSM; stop outranks pause, pause outranks start. A write in
    // flight always completes before a stop/pause takes effect.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_we_n       <= 1'b1;
            r_len        <= '0;
            r_full       <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_we_cnt     <= '0;
            r_pend_stop  <= 1'b0;
            r_pend_pause <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start && !i_pause && !i_stop) begin
                        r_addr  <= '0;
                        r_len   <= '0;
                        r_full  <= 1'b0;
                        r_state <= ST_WAIT_L;
                    end
                end
                ST_WAIT_L: begin
                    if (i_stop)         r_state <= ST_DONE;
                    else if (i_pause)   r_state <= ST_PAUSED;
                    else if (w_lr_fall) r_state <= ST_SKIP;
                end
                ST_SKIP: begin
                    if (i_stop)       r_state <= ST_DONE;
                    else if (i_pause) r_state <= ST_PAUSED;
                    else if (w_bclk_rise) begin
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (i_stop)         r_state <= ST_DONE;
                    else if (i_pause)   r_state <= ST_PAUSED;
                    else if (w_lr_rise) r_state <= ST_WAIT_L;
                    else if (w_bclk_rise) begin
                        r_shift   <= w_shift_nx[DATA_W-2:0];
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'(I2S_BITS - 1)) begin
                            r_data       <= w_wdata;
                            r_we_n       <= 1'b0;
                            r_we_cnt     <= '0;
                            r_pend_stop  <= 1'b0;
                            r_pend_pause <= 1'b0;
                            r_state      <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (i_stop)  r_pend_stop  <= 1'b1;
                    if (i_pause) r_pend_pause <= 1'b1;
                    if (r_we_cnt == 2'(WE_CYCLES - 1)) begin
                        r_we_n <= 1'b1;
                        r_len  <= w_len_nx;
                        if (w_len_nx == DEPTH_L) begin
                            // Address stays on the last word: it never wraps.
                            r_full  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                            if (r_pend_stop || i_stop)        r_state <= ST_DONE;
                            else if (r_pend_pause || i_pause) r_state <= ST_PAUSED;
                            else                              r_state <= ST_WAIT_L;
                        end
                    end else begin
                        r_we_cnt <= r_we_cnt + 2'd1;
                    end
                end
                ST_PAUSED: begin
                    if (i_stop)                   r_state <= ST_DONE;
                    else if (i_start && !i_pause) r_state <= ST_WAIT_L;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sram_addr = r_addr;
    assign o_sram_data = r_data;
    assign o_sram_we_n = r_we_n;
    assign o_rec_len   = r_len;
    assign o_full      = r_full;
    assign o_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule

// File: tb/tb_aud_rec_writer.sv
// Randomised bench for aud_rec_writer: an I2S source drives two DUTs (full
// size and an 8-word variant); a bus monitor collects SRAM writes and a
// frame-level model predicts which left samples land at which address.
module tb_aud_rec_writer;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    typedef struct {
        int addr;
        int data;
        int low;
        bit stable;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic start, pause, stop, start_s, pause_s, stop_s;
    logic bclk, lrck, dat;
`ifdef REC_GAIN_EN
    logic [1:0] gain;
`endif

    logic [ADDR_W-1:0] addr, addr_s;
    logic [DATA_W-1:0] data, data_s;
    logic              we_n, we_n_s, busy, busy_s, full, full_s;
    logic [ADDR_W:0]   len, len_s;

    int n_cmp = 0;
    int n_err = 0;
    int hp    = 4;
    int m_len;
    wr_t wr_q[$], wr_q_s[$], exp_q[$];

    always #5 clk = ~clk;

    aud_rec_writer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_bclk(bclk), .i_adclrck(lrck), .i_adcdat(dat),
`ifdef REC_GAIN_EN
        .i_gain(gain),
`endif
        .o_sram_addr(addr), .o_sram_data(data), .o_sram_we_n(we_n),
        .o_rec_len(len), .o_busy(busy), .o_full(full)
    );

    aud_rec_writer #(.MEM_DEPTH(8)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_pause(pause_s), .i_stop(stop_s),
        .i_bclk(bclk), .i_adclrck(lrck), .i_adcdat(dat),
`ifdef REC_GAIN_EN
        .i_gain(gain),
`endif
        .o_sram_addr(addr_s), .o_sram_data(data_s), .o_sram_we_n(we_n_s),
        .o_rec_len(len_s), .o_busy(busy_s), .o_full(full_s)
    );

    // SRAM bus monitors: one record per we_n low pulse.
    wr_t cur, cur_s;
    int  cnt = 0, cnt_s = 0;
    always @(negedge clk) begin
        if (!we_n) begin
            if (cnt == 0) begin cur.addr = int'(addr); cur.data = int'(data); cur.stable = 1; end
            else if (int'(addr) != cur.addr || int'(data) != cur.data) cur.stable = 0;
            cnt++;
        end else if (cnt != 0) begin
            cur.low = cnt; wr_q.push_back(cur); cnt = 0;
        end
        if (!we_n_s) begin
            if (cnt_s == 0) begin cur_s.addr = int'(addr_s); cur_s.data = int'(data_s); cur_s.stable = 1; end
            else if (int'(addr_s) != cur_s.addr || int'(data_s) != cur_s.data) cur_s.stable = 0;
            cnt_s++;
        end else if (cnt_s != 0) begin
            cur_s.low = cnt_s; wr_q_s.push_back(cur_s); cnt_s = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference for the value stored: sample times 2^gain, clamped to int16.
    function automatic int model_val(input logic [15:0] s);
        int v;
        v = int'($signed(s));
`ifdef REC_GAIN_EN
        v = v * (1 << gain);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
`endif
        return v & 32'hFFFF;
    endfunction

    task automatic expect_write(input logic [15:0] s);
        wr_t e;
        e.addr = m_len; e.data = model_val(s); e.low = 2; e.stable = 1;
        exp_q.push_back(e);
        m_len++;
    endtask

    task automatic set_ctrl(input int code, input logic v);
        case (code)
            1: start   = v;
            2: pause   = v;
            3: stop    = v;
            4: start_s = v;
            default: ;
        endcase
    endtask

    task automatic pulse(input int code);
        @(negedge clk); set_ctrl(code, 1'b1);
        @(negedge clk); set_ctrl(code, 1'b0);
    endtask

    // One bclk period; lrclk/data change on the falling edge.
    task automatic send_bit(input logic lr, input logic d, input int code);
        @(negedge clk); bclk = 1'b0; lrck = lr; dat = d; set_ctrl(code, 1'b1);
        @(negedge clk); set_ctrl(code, 1'b0);
        repeat (hp - 2) @(negedge clk);
        bclk = 1'b1;
        repeat (hp - 1) @(negedge clk);
    endtask

    // I2S frame: delay bit, lbits data bits MSB first, pad; then right slot.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int lbits,
                              input int code, input int cbit);
        send_bit(1'b0, 1'b0, (cbit == 0) ? code : 0);
        for (int i = 0; i < lbits; i++) send_bit(1'b0, l[15-i], (cbit == i + 1) ? code : 0);
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        for (int i = 0; i < 16; i++) send_bit(1'b1, r[15-i], 0);
        send_bit(1'b1, 1'b0, 0);
    endtask

    task automatic rand_frame(input bit expected);
        logic [15:0] l, r;
        l  = 16'($urandom);
        r  = 16'($urandom);
        hp = $urandom_range(2, 5);
        send_frame(l, r, 16, 0, -1);
        if (expected) expect_write(l);
    endtask

    // Pulse a control line during the first cycle the big DUT has we_n low.
    task automatic pulse_on_write(input int code);
        int n = 0;
        @(negedge clk);
        while (we_n !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        chk("write_seen", 32'(n < 2000), 32'd1);
        set_ctrl(code, 1'b1);
        @(negedge clk); set_ctrl(code, 1'b0);
    endtask

    task automatic check_writes(input string tag, input bit sel);
        wr_t got[$];
        if (sel) got = wr_q_s; else got = wr_q;
        chk($sformatf("%s_nwr", tag), 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), got[i].addr, exp_q[i].addr);
            chk($sformatf("%s_data%0d", tag, i), got[i].data, exp_q[i].data);
            chk($sformatf("%s_we_low%0d", tag, i), got[i].low, exp_q[i].low);
            chk($sformatf("%s_stable%0d", tag, i), 32'(got[i].stable), 32'd1);
        end
        wr_q.delete(); wr_q_s.delete(); exp_q.delete();
    endtask

    initial begin
        logic [15:0] fixed [4];
        logic [15:0] l;
        fixed[0] = 16'h1234; fixed[1] = 16'hABCD; fixed[2] = 16'h0001; fixed[3] = 16'h8000;
        rst = 1'b1; start = 0; pause = 0; stop = 0; start_s = 0; pause_s = 0; stop_s = 0;
        bclk = 1'b0; lrck = 1'b1; dat = 1'b0;
`ifdef REC_GAIN_EN
        gain = 2'($urandom_range(0, 3));
`endif
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_we_n", 32'(we_n), 1);
        chk("rst_len", 32'(len), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_full", 32'(full), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic capture, random frames, and a left slot cut short by lrclk.
        pulse(1);
        chk("start_busy", 32'(busy), 1);
        m_len = 0;
        for (int i = 0; i < 4; i++) begin
            send_frame(fixed[i], 16'hFFFF, 16, 0, -1);
            expect_write(fixed[i]);
        end
        for (int i = 0; i < 4; i++) rand_frame(1);
        send_frame(16'($urandom), 16'($urandom), 10, 0, -1);
        rand_frame(1);
        check_writes("basic", 0);
        chk("basic_len", 32'(len), 32'(m_len));

        // Pause mid-sample, resume; pause during a write is deferred.
        pulse(3);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_full", 32'(full), 0);
        pulse(1);
        m_len = 0;
        rand_frame(1); rand_frame(1);
        send_frame(16'($urandom), 16'($urandom), 16, 2, 8);
        chk("paused_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) rand_frame(0);
        pulse(1);
        rand_frame(1);
        l = 16'($urandom);
        fork
            send_frame(l, 16'($urandom), 16, 0, -1);
            pulse_on_write(2);
        join
        expect_write(l);
        rand_frame(0); rand_frame(0);
        pulse(1);
        rand_frame(1);
        check_writes("pause", 0);
        chk("pause_len", 32'(len), 32'(m_len));

        // Stop arriving during the fifth write.
        pulse(3); pulse(1);
        m_len = 0;
        for (int i = 0; i < 4; i++) rand_frame(1);
        l = 16'($urandom);
        fork
            send_frame(l, 16'($urandom), 16, 0, -1);
            pulse_on_write(3);
        join
        expect_write(l);
        chk("stopw_busy", 32'(busy), 0);
        chk("stopw_full", 32'(full), 0);
        rand_frame(0);
        check_writes("stopw", 0);
        chk("stopw_len", 32'(len), 5);

        // Saturating depth on the 8-word instance.
        pulse(4);
        m_len = 0;
        for (int i = 0; i < 10; i++) rand_frame(m_len < 8);
        chk("full_flag", 32'(full_s), 1);
        chk("full_len", 32'(len_s), 8);
        chk("full_busy", 32'(busy_s), 0);
        chk("full_big_idle", 32'(wr_q.size()), 0);
        check_writes("full", 1);

`ifdef REC_GAIN_EN
        // Gain of 2: one in-range value, one positive and one negative clamp.
        pulse(1);
        gain = 2'd2;
        hp = 3;
        send_frame(16'h1000, 16'hFFFF, 16, 0, -1);
        send_frame(16'h3000, 16'hFFFF, 16, 0, -1);
        send_frame(16'hD000, 16'hFFFF, 16, 0, -1);
        chk("gain_nwr", 32'(wr_q.size()), 3);
        if (wr_q.size() == 3) begin
            chk("gain_4000", 32'(wr_q[0].data), 32'h4000);
            chk("gain_7fff", 32'(wr_q[1].data), 32'h7FFF);
            chk("gain_8000", 32'(wr_q[2].data), 32'h8000);
        end
        wr_q.delete();
        pulse(3);
`endif

        // Asynchronous reset while we_n is low.
        pulse(1);
        m_len = 0;
        rand_frame(1);
        fork
            send_frame(16'($urandom), 16'($urandom), 16, 0, -1);
            begin
                int n = 0;
                @(negedge clk);
                while (we_n !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
                chk("rstw_seen", 32'(n < 2000), 32'd1);
                chk("rstw_len_before", 32'(len), 1);
                rst = 1'b1;
                #1;
                chk("rstw_we_n", 32'(we_n), 1);
                chk("rstw_addr", 32'(addr), 0);
                chk("rstw_data", 32'(data), 0);
                chk("rstw_len", 32'(len), 0);
                chk("rstw_busy", 32'(busy), 0);
                chk("rstw_full", 32'(full), 0);
            end
        join
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstw_idle_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
